// File: rtl/acq_search_sched_if.sv
// Correlator-side channel of acq_search_sched: tuning outputs, dump pulse,
// integration flag and prompt accumulators.
interface acq_search_sched_if;
    logic [4:0]  satellite_id;
    logic [29:0] carr_frequency;
    logic        dump_clr;
    logic        intg_ready;
    logic [19:0] prompt_idata;
    logic [19:0] prompt_qdata;

    modport master (
        output satellite_id, carr_frequency, dump_clr,
        input  intg_ready, prompt_idata, prompt_qdata
    );

    modport slave (
        input  satellite_id, carr_frequency, dump_clr,
        output intg_ready, prompt_idata, prompt_qdata
    );
endinterface

// File: rtl/acq_search_sched.sv
// GPS acquisition sweep: steps satellite/carrier bins, tracks the strongest |I|+|Q| hit.
// Define ACQ_EARLY_EXIT_EN to stop the sweep at the first bin reaching threshold.
module acq_search_sched #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd2_000_000,
    parameter int unsigned BIN_W       = 6
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    input  logic                 abort,
    input  logic [4:0]           sat_lo,
    input  logic [4:0]           sat_hi,
    input  logic [29:0]          carr_base,
    input  logic [29:0]          carr_step,
    input  logic [BIN_W-1:0]     num_bins,
    input  logic [20:0]          threshold,
    acq_search_sched_if.master   corr,
    output logic                 busy,
    output logic                 done,
    output logic                 found,
    output logic                 timeout,
    output logic [4:0]           best_sat,
    output logic [29:0]          best_carr,
    output logic [20:0]          best_mag
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PROGRAM = 3'd1;
    localparam logic [2:0] S_DISCARD = 3'd2;
    localparam logic [2:0] S_INTEG   = 3'd3;
    localparam logic [2:0] S_EVAL    = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]       state;
    logic [2:0]       sync;
    logic             evt;
    logic [4:0]       sat_cur, sat_end;
    logic [BIN_W-1:0] bin_cur, bins_cfg;
    logic [BIN_W:0]   bin_inc;
    logic [29:0]      carr_cur, base_cfg, step_cfg;
    logic [20:0]      thr_cfg;
    logic [19:0]      i_cap, q_cap;
    logic [31:0]      wdog;
    logic [20:0]      abs_i, abs_q, mag, best_nxt;
    logic             bin_last, wdog_hit;

    // Integration event: falling edge after the two synchroniser stages.
    assign evt = ~sync[1] & sync[2];

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign corr.dump_clr = (state == S_PROGRAM);

    always_comb begin
        abs_i    = i_cap[19] ? (21'd0 - {i_cap[19], i_cap}) : {1'b0, i_cap};
        abs_q    = q_cap[19] ? (21'd0 - {q_cap[19], q_cap}) : {1'b0, q_cap};
        mag      = abs_i + abs_q;
        best_nxt = (mag > best_mag) ? mag : best_mag;
        // num_bins of 0 behaves as 1: the first bin is always the last one.
        bin_inc  = {1'b0, bin_cur} + {{BIN_W{1'b0}}, 1'b1};
        bin_last = (bin_inc >= {1'b0, bins_cfg});
        wdog_hit = (wdog == TIMEOUT_CYC - 32'd1);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state               <= S_IDLE;
            sync                <= '0;
            sat_cur             <= '0;
            sat_end             <= '0;
            bin_cur             <= '0;
            bins_cfg            <= '0;
            carr_cur            <= '0;
            base_cfg            <= '0;
            step_cfg            <= '0;
            thr_cfg             <= '0;
            i_cap               <= '0;
            q_cap               <= '0;
            wdog                <= '0;
            found               <= 1'b0;
            timeout             <= 1'b0;
            best_sat            <= '0;
            best_carr           <= '0;
            best_mag            <= '0;
            corr.satellite_id   <= '0;
            corr.carr_frequency <= '0;
        end else begin
            sync <= {sync[1:0], corr.intg_ready};
            if (abort) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        sat_cur   <= sat_lo;
                        sat_end   <= sat_hi;
                        bin_cur   <= '0;
                        bins_cfg  <= num_bins;
                        carr_cur  <= carr_base;
                        base_cfg  <= carr_base;
                        step_cfg  <= carr_step;
                        thr_cfg   <= threshold;
                        best_sat  <= '0;
                        best_carr <= '0;
                        best_mag  <= '0;
                        found     <= 1'b0;
                        timeout   <= 1'b0;
                        state     <= S_PROGRAM;
                    end
                    S_PROGRAM: begin
                        corr.satellite_id   <= sat_cur;
                        corr.carr_frequency <= carr_cur;
                        wdog                <= '0;
                        state               <= S_DISCARD;
                    end
                    S_DISCARD, S_INTEG: begin
                        wdog <= wdog + 32'd1;
                        if (evt) begin
                            if (state == S_INTEG) begin
                                i_cap <= corr.prompt_idata;
                                q_cap <= corr.prompt_qdata;
                                state <= S_EVAL;
                            end else begin
                                state <= S_INTEG;
                            end
                        end else if (wdog_hit) begin
                            timeout <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                    S_EVAL:
`ifdef ACQ_EARLY_EXIT_EN
                    if (mag >= thr_cfg) begin
                        best_mag  <= mag;
                        best_sat  <= sat_cur;
                        best_carr <= carr_cur;
                        found     <= 1'b1;
                        state     <= S_DONE;
                    end else
`endif
                    begin
                        // Strict compare keeps the earlier bin on a tie.
                        if (mag > best_mag) begin
                            best_mag  <= mag;
                            best_sat  <= sat_cur;
                            best_carr <= carr_cur;
                        end
                        found <= (best_nxt >= thr_cfg);
                        state <= S_NEXT;
                    end
                    S_NEXT: begin
                        if (!bin_last) begin
                            bin_cur  <= bin_cur + 1'b1;
                            carr_cur <= carr_cur + step_cfg;
                            state    <= S_PROGRAM;
                        end else if (sat_cur != sat_end) begin
                            sat_cur  <= sat_cur + 5'd1;
                            bin_cur  <= '0;
                            carr_cur <= base_cfg;
                            state    <= S_PROGRAM;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
